// File: rtl/calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calculator_pkg
// Description : Shared widths, address type and controller state encoding
//               for the calculator datapath.
//               DATA_W        - operand/result width
//               MEM_WORD_SIZE - memory word width (two operands per word)
//               ADDR_W        - memory address width
// Revision    : 1.0 - initial release
// ============================================================================
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 2 * DATA_W;
    localparam int ADDR_W        = 10;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_BUF   = 3'd4,
        S_PAD   = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_controller.sv
`default_nettype none
// ============================================================================
// Module      : calc_controller
// Description : Sequencing FSM for the calculator datapath. Reads 64-bit
//               words over an inclusive address range, splits each into two
//               32-bit adder operands, steers each sum into the lower/upper
//               half of result_buffer and writes the packed word back once
//               both halves are fresh (odd counts pad the upper half with 0).
// Ports       : clk_i, rst_ni (async, active-low)
//               start_i, read_start_addr_i, read_end_addr_i,
//               write_start_addr_i          - run request
//               mem_rdata_i, mem_addr_o, mem_rd_en_o, mem_wr_en_o - memory
//               op_a_o, op_b_o, loc_sel_o   - adder / result_buffer steering
//               busy_o, done_o              - status
//               abort_i                     - only with CALC_ABORT_EN
// Options     : CALC_ABORT_EN - adds abort_i; forces S_DONE from any busy
//               state and suppresses the pending write.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_controller
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef CALC_ABORT_EN
    input  logic                     abort_i,
`endif
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        read_start_addr_i,
    input  logic [ADDR_W-1:0]        read_end_addr_i,
    input  logic [ADDR_W-1:0]        write_start_addr_i,
    input  logic [MEM_WORD_SIZE-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic                     mem_rd_en_o,
    output logic                     mem_wr_en_o,
    output logic [DATA_W-1:0]        op_a_o,
    output logic [DATA_W-1:0]        op_b_o,
    output logic                     loc_sel_o,
    output logic                     busy_o,
    output logic                     done_o
);

    state_t r_state;
    addr_t  r_rd_ptr;
    addr_t  r_rd_end;
    addr_t  r_wr_ptr;
    logic   r_half;

    addr_t  w_rd_next;
    logic   w_abort;

    assign w_rd_next = r_rd_ptr + addr_t'(1);

    // S_DONE is excluded so an abort held across the end of a run cannot
    // stretch the done pulse.
`ifdef CALC_ABORT_EN
    assign w_abort = abort_i && (r_state != S_IDLE) && (r_state != S_DONE);
`else
    assign w_abort = 1'b0;
`endif

    // All outputs are registered: each transition also loads the output
    // values belonging to the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_rd_end    <= '0;
            r_wr_ptr    <= '0;
            r_half      <= 1'b0;
            mem_addr_o  <= '0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            op_a_o      <= '0;
            op_b_o      <= '0;
            loc_sel_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            done_o      <= 1'b0;

            if (w_abort) begin
                r_state <= S_DONE;
                done_o  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_rd_ptr <= read_start_addr_i;
                            r_rd_end <= read_end_addr_i;
                            r_wr_ptr <= write_start_addr_i;
                            r_half   <= 1'b0;
                            busy_o   <= 1'b1;
                            if (read_end_addr_i < read_start_addr_i) begin
                                r_state <= S_DONE;
                                done_o  <= 1'b1;
                            end else begin
                                r_state     <= S_READ;
                                mem_addr_o  <= read_start_addr_i;
                                mem_rd_en_o <= 1'b1;
                            end
                        end
                    end
                    S_READ: r_state <= S_WAIT;
                    S_WAIT: r_state <= S_LOAD;
                    S_LOAD: begin
                        op_a_o    <= mem_rdata_i[MEM_WORD_SIZE-1:DATA_W];
                        op_b_o    <= mem_rdata_i[DATA_W-1:0];
                        loc_sel_o <= r_half;
                        r_state   <= S_BUF;
                    end
                    S_BUF: begin
                        if (r_half) begin
                            r_state     <= S_WRITE;
                            mem_addr_o  <= r_wr_ptr;
                            mem_wr_en_o <= 1'b1;
                        end else if (r_rd_ptr != r_rd_end) begin
                            r_half      <= 1'b1;
                            r_rd_ptr    <= w_rd_next;
                            r_state     <= S_READ;
                            mem_addr_o  <= w_rd_next;
                            mem_rd_en_o <= 1'b1;
                        end else begin
                            // Odd word count: upper half captures a zero sum.
                            op_a_o    <= '0;
                            op_b_o    <= '0;
                            loc_sel_o <= 1'b1;
                            r_state   <= S_PAD;
                        end
                    end
                    S_PAD: begin
                        r_state     <= S_WRITE;
                        mem_addr_o  <= r_wr_ptr;
                        mem_wr_en_o <= 1'b1;
                    end
                    S_WRITE: begin
                        r_wr_ptr <= r_wr_ptr + addr_t'(1);
                        r_half   <= 1'b0;
                        // Equality compare so that an end address of all-ones
                        // terminates even though the pointer wraps.
                        if (r_rd_ptr == r_rd_end) begin
                            r_state <= S_DONE;
                            done_o  <= 1'b1;
                        end else begin
                            r_rd_ptr    <= w_rd_next;
                            r_state     <= S_READ;
                            mem_addr_o  <= w_rd_next;
                            mem_rd_en_o <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_controller
// Description : Directed self-checking bench for calc_controller. Surrounds
//               the controller with a synchronous memory, the adder and a
//               result_buffer model; expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_controller;
    import calculator_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    addr_t       read_start_addr_i;
    addr_t       read_end_addr_i;
    addr_t       write_start_addr_i;
    logic [63:0] mem_rdata_i;
    addr_t       mem_addr_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] op_a_o;
    logic [31:0] op_b_o;
    logic        loc_sel_o;
    logic        busy_o;
    logic        done_o;
`ifdef CALC_ABORT_EN
    logic        abort_i;
`endif

    always #5 clk_i = ~clk_i;

    calc_controller dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
`ifdef CALC_ABORT_EN
        .abort_i            (abort_i),
`endif
        .start_i            (start_i),
        .read_start_addr_i  (read_start_addr_i),
        .read_end_addr_i    (read_end_addr_i),
        .write_start_addr_i (write_start_addr_i),
        .mem_rdata_i        (mem_rdata_i),
        .mem_addr_o         (mem_addr_o),
        .mem_rd_en_o        (mem_rd_en_o),
        .mem_wr_en_o        (mem_wr_en_o),
        .op_a_o             (op_a_o),
        .op_b_o             (op_b_o),
        .loc_sel_o          (loc_sel_o),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    int errors = 0;
    int checks = 0;

    // Environment: memory with registered read data, adder, result_buffer.
    logic [63:0] mem [0:1023];
    logic [63:0] buf_q;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    addr_t       last_rd_addr;
    addr_t       last_wr_addr;
    logic [63:0] last_wr_data;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) buf_q <= '0;
        else if (loc_sel_o) buf_q[63:32] <= op_a_o + op_b_o;
        else buf_q[31:0] <= op_a_o + op_b_o;
    end

    always @(posedge clk_i) begin
        if (mem_rd_en_o) begin
            mem_rdata_i  <= mem[mem_addr_o];
            rd_cnt       = rd_cnt + 1;
            last_rd_addr = mem_addr_o;
        end
        if (mem_wr_en_o) begin
            mem[mem_addr_o] <= buf_q;
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = mem_addr_o;
            last_wr_data = buf_q;
        end
        if (mem_rd_en_o && mem_wr_en_o) overlap_cnt = overlap_cnt + 1;
    end

    // Runs one request; cycles counts negedges from the start pulse to the
    // one where done_o is seen. A start pulse with other addresses is
    // injected at cycle glitch_at (0 = none).
    task automatic run(input addr_t rs, input addr_t re, input addr_t ws,
                       input int glitch_at, output int cycles, output int busy_cyc);
        @(negedge clk_i);
        read_start_addr_i  = rs;
        read_end_addr_i    = re;
        write_start_addr_i = ws;
        start_i            = 1'b1;
        @(negedge clk_i);
        start_i  = 1'b0;
        cycles   = 1;
        busy_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy_o) busy_cyc++;
            if (done_o) break;
            if (cycles == glitch_at) begin
                start_i            = 1'b1;
                read_start_addr_i  = 10'h000;
                read_end_addr_i    = 10'h001;
                write_start_addr_i = 10'h055;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            cycles++;
        end
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL run_timeout: done_o=%b required 1 within 100 cycles", done_o);
        end
    endtask

    task automatic test_reset();
        int wr0;
        checks++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o, loc_sel_o} !== 5'b0 ||
            op_a_o !== 32'h0 || op_b_o !== 32'h0 || mem_addr_o !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b sel=%b a=%h b=%h addr=%h required all 0",
                     busy_o, done_o, mem_rd_en_o, mem_wr_en_o, loc_sel_o, op_a_o, op_b_o, mem_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        // Start a two-word run and reset it during the first S_BUF.
        wr0 = wr_cnt;
        @(negedge clk_i);
        read_start_addr_i  = 10'h000;
        read_end_addr_i    = 10'h001;
        write_start_addr_i = 10'h070;
        start_i            = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (op_a_o !== 32'h1 || op_b_o !== 32'h2 || loc_sel_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL first_buf: a=%h b=%h sel=%b busy=%b required 1 2 0 1",
                     op_a_o, op_b_o, loc_sel_o, busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, mem_rd_en_o, mem_wr_en_o, loc_sel_o} !== 5'b0 ||
            op_a_o !== 32'h0 || op_b_o !== 32'h0 || mem_addr_o !== 10'h0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b rd=%b wr=%b sel=%b a=%h b=%h addr=%h required all 0",
                     busy_o, done_o, mem_rd_en_o, mem_wr_en_o, loc_sel_o, op_a_o, op_b_o, mem_addr_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        checks++;
        if (wr_cnt - wr0 !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: writes=%0d busy=%b required 0 writes, busy 0",
                     wr_cnt - wr0, busy_o);
        end
    endtask

    task automatic test_two_word();
        int cyc, bcyc, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(10'h000, 10'h001, 10'h080, 0, cyc, bcyc);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL two_word_latency: got %0d cycles required 10", cyc);
        end
        checks++;
        if (rd_cnt - rd0 !== 2 || wr_cnt - wr0 !== 1) begin
            errors++;
            $display("FAIL two_word_strobes: reads=%0d writes=%0d required 2 and 1", rd_cnt - rd0, wr_cnt - wr0);
        end
        checks++;
        if (last_wr_addr !== 10'h080 || last_wr_data !== 64'h00000030_00000003) begin
            errors++;
            $display("FAIL two_word_data: addr=%h data=%h required 080 0000003000000003",
                     last_wr_addr, last_wr_data);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL two_word_end: done=%b busy=%b required 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_odd_count();
        int cyc, bcyc, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(10'h004, 10'h004, 10'h090, 0, cyc, bcyc);
        checks++;
        if (cyc !== 7 || rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin
            errors++;
            $display("FAIL odd_strobes: cycles=%0d reads=%0d writes=%0d required 7 1 1",
                     cyc, rd_cnt - rd0, wr_cnt - wr0);
        end
        checks++;
        if (last_wr_addr !== 10'h090 || last_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL odd_data: addr=%h data=%h required 090 0000000000000000",
                     last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_empty_range();
        int cyc, bcyc, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(10'h005, 10'h004, 10'h0B0, 0, cyc, bcyc);
        checks++;
        if (cyc !== 1 || bcyc !== 1 || rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin
            errors++;
            $display("FAIL empty_range: cycles=%0d busy_cycles=%0d reads=%0d writes=%0d required 1 1 0 0",
                     cyc, bcyc, rd_cnt - rd0, wr_cnt - wr0);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_end: busy=%b done=%b required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_addr_wrap();
        int cyc, bcyc, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(10'h3FF, 10'h3FF, 10'h100, 3, cyc, bcyc);
        checks++;
        if (cyc !== 7 || rd_cnt - rd0 !== 1 || last_rd_addr !== 10'h3FF) begin
            errors++;
            $display("FAIL wrap_read: cycles=%0d reads=%0d rd_addr=%h required 7 1 3ff",
                     cyc, rd_cnt - rd0, last_rd_addr);
        end
        checks++;
        if (wr_cnt - wr0 !== 1 || last_wr_addr !== 10'h100 || last_wr_data !== 64'h00000000_0000000C) begin
            errors++;
            $display("FAIL wrap_write: writes=%0d addr=%h data=%h required 1 100 000000000000000c",
                     wr_cnt - wr0, last_wr_addr, last_wr_data);
        end
        repeat (10) @(negedge clk_i);
        checks++;
        if (rd_cnt - rd0 !== 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_after: reads=%0d busy=%b required 1 0", rd_cnt - rd0, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        run(10'h008, 10'h00A, 10'h0A0, 0, cyc, bcyc);
        checks++;
        if (cyc !== 16 || rd_cnt - rd0 !== 3 || wr_cnt - wr0 !== 2) begin
            errors++;
            $display("FAIL b2b_strobes: cycles=%0d reads=%0d writes=%0d required 16 3 2",
                     cyc, rd_cnt - rd0, wr_cnt - wr0);
        end
        checks++;
        if (mem[10'h0A0] !== 64'h00000005_00000002) begin
            errors++;
            $display("FAIL b2b_word0: got %h required 0000000500000002", mem[10'h0A0]);
        end
        checks++;
        if (mem[10'h0A1] !== 64'h00000000_80000000) begin
            errors++;
            $display("FAIL b2b_word1: got %h required 0000000080000000", mem[10'h0A1]);
        end
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes required 0", overlap_cnt);
        end
    endtask

`ifdef CALC_ABORT_EN
    task automatic test_abort();
        int wr0;
        wr0 = wr_cnt;
        @(negedge clk_i);
        read_start_addr_i  = 10'h000;
        read_end_addr_i    = 10'h001;
        write_start_addr_i = 10'h0C0;
        start_i            = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (mem_rd_en_o !== 1'b1 || mem_addr_o !== 10'h001) begin
            errors++;
            $display("FAIL abort_second_read: rd=%b addr=%h required 1 001", mem_rd_en_o, mem_addr_o);
        end
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_done: done=%b required 1", done_o);
        end
        @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || wr_cnt - wr0 !== 0 || mem[10'h0C0] !== 64'hDEAD) begin
            errors++;
            $display("FAIL abort_no_write: busy=%b writes=%0d mem=%h required 0 0 dead",
                     busy_o, wr_cnt - wr0, mem[10'h0C0]);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'h0;
        mem[10'h000] = 64'h00000001_00000002;
        mem[10'h001] = 64'h00000010_00000020;
        mem[10'h004] = 64'hFFFFFFFF_00000001;
        mem[10'h008] = 64'h00000001_00000001;
        mem[10'h009] = 64'h00000002_00000003;
        mem[10'h00A] = 64'h7FFFFFFF_00000001;
        mem[10'h0C0] = 64'hDEAD;
        mem[10'h3FF] = 64'h00000005_00000007;
        mem_rdata_i        = '0;
        rst_ni             = 1'b0;
        start_i            = 1'b0;
        read_start_addr_i  = '0;
        read_end_addr_i    = '0;
        write_start_addr_i = '0;
`ifdef CALC_ABORT_EN
        abort_i = 1'b0;
`endif
        #23;
        test_reset();
        test_two_word();
        test_odd_count();
        test_empty_range();
        test_addr_wrap();
        test_back_to_back();
`ifdef CALC_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
